// File: rtl/sd_rr_arbiter.sv
// sd_rr_arbiter: round-robin arbiter sharing one registered srdy/drdy output among N inputs,
// with optional packet lock that holds the grant from first word through eop.
module sd_rr_arbiter #(
  parameter int width = 8,
  parameter int inputs = 4,
  parameter bit lock_mode = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  input  logic [inputs-1:0]       c_eop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic                    p_eop,
  output logic [inputs-1:0]       p_grant
);
  localparam int pw = $clog2(inputs);
  typedef enum logic {idle, locked} state_t;
  state_t state;
  logic [pw-1:0] last, lock_idx, rr_sel, cand, sel;
  logic found, space, req, load;
  logic [inputs-1:0] onehot;
  // first requester after the last winner, wrapping modulo inputs
  always_comb begin
    rr_sel = last;
    cand = last;
    found = 1'b0;
    for (int i = 1; i <= inputs; i++) begin
      cand = pw'((int'(last) + i) % inputs);
      if (!found && c_srdy[cand]) begin
        rr_sel = cand;
        found = 1'b1;
      end
    end
  end
  assign sel = (state == locked) ? lock_idx : rr_sel;
  assign req = (state == locked) | found;
  assign space = !p_srdy | p_drdy;
  assign load = space & req & c_srdy[sel];
  assign onehot = inputs'(1) << sel;
  assign c_drdy = (space & req) ? onehot : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= idle;
      last <= pw'(inputs - 1);
      lock_idx <= '0;
      p_srdy <= 1'b0;
      p_eop <= 1'b0;
      p_grant <= '0;
    end else if (load) begin
      state <= (lock_mode && !c_eop[sel]) ? locked : idle;
      last <= sel;
      lock_idx <= sel;
      p_srdy <= 1'b1;
      p_eop <= c_eop[sel];
      p_grant <= onehot;
    end else if (p_drdy) begin
      p_srdy <= 1'b0;
    end
  end
  // data path carries no reset; it is qualified by p_srdy
  always_ff @(posedge clk)
    if (load) p_data <= c_data[sel*width +: width];
endmodule

// File: tb/tb_sd_rr_arbiter.sv
// tb_sd_rr_arbiter: checks a packet-locking and a plain round-robin instance against a
// cycle model every cycle, plus directed literal expectations and random traffic.
module tb_sd_rr_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] srdy = '0, eop = '0;
  logic [31:0] data = '0;
  logic pdrdy = 1'b0;
  logic [3:0] drdy_lk, grant_lk, drdy_rr, grant_rr;
  logic psrdy_lk, peop_lk, psrdy_rr, peop_rr;
  logic [7:0] pdata_lk, pdata_rr;
  int compared = 0, mismatched = 0;

  sd_rr_arbiter #(.width(8), .inputs(4), .lock_mode(1'b1)) u_lk (
    .clk(clk), .reset(reset), .c_srdy(srdy), .c_drdy(drdy_lk), .c_data(data), .c_eop(eop),
    .p_srdy(psrdy_lk), .p_drdy(pdrdy), .p_data(pdata_lk), .p_eop(peop_lk), .p_grant(grant_lk));
  sd_rr_arbiter #(.width(8), .inputs(4), .lock_mode(1'b0)) u_rr (
    .clk(clk), .reset(reset), .c_srdy(srdy), .c_drdy(drdy_rr), .c_data(data), .c_eop(eop),
    .p_srdy(psrdy_rr), .p_drdy(pdrdy), .p_data(pdata_rr), .p_eop(peop_rr), .p_grant(grant_rr));

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // model state: index 0 = packet-locking instance, 1 = per-word instance
  int mlast[2] = '{3, 3};
  int mlidx[2] = '{0, 0};
  bit mlock[2] = '{0, 0};
  bit msrdy[2] = '{0, 0};
  bit meop[2] = '{0, 0};
  logic [7:0] mdata[2];
  logic [3:0] mgrant[2] = '{4'b0, 4'b0};

  task automatic model_step(int m, string p, logic [3:0] g_drdy, logic g_srdy, logic [7:0] g_data,
                            logic g_eop, logic [3:0] g_grant);
    bit space, has;
    int sel;
    logic [3:0] exp_drdy;
    if (reset) begin
      mlast[m] = 3; mlock[m] = 0; msrdy[m] = 0; meop[m] = 0; mgrant[m] = 4'b0;
    end
    chk({p, " p_srdy"}, 32'(g_srdy), 32'(msrdy[m]));
    chk({p, " p_grant"}, 32'(g_grant), 32'(mgrant[m]));
    chk({p, " p_eop"}, 32'(g_eop), 32'(meop[m]));
    if (msrdy[m]) chk({p, " p_data"}, 32'(g_data), 32'(mdata[m]));
    space = !msrdy[m] || pdrdy;
    has = 0;
    sel = 0;
    if (mlock[m]) begin
      sel = mlidx[m];
      has = 1;
    end else begin
      for (int i = 1; i <= 4; i++)
        if (!has && srdy[(mlast[m] + i) % 4]) begin
          sel = (mlast[m] + i) % 4;
          has = 1;
        end
    end
    exp_drdy = (space && has) ? 4'(1 << sel) : 4'b0;
    chk({p, " c_drdy"}, 32'(g_drdy), 32'(exp_drdy));
    if (!reset) begin
      if (space && has && srdy[sel]) begin
        msrdy[m] = 1; mdata[m] = data[sel*8 +: 8]; meop[m] = eop[sel];
        mgrant[m] = 4'(1 << sel); mlast[m] = sel; mlidx[m] = sel;
        mlock[m] = (m == 0) && !eop[sel];
      end else if (pdrdy) begin
        msrdy[m] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, "lk", drdy_lk, psrdy_lk, pdata_lk, peop_lk, grant_lk);
    model_step(1, "rr", drdy_rr, psrdy_rr, pdata_rr, peop_rr, grant_rr);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int seq[4], outseq[4];
  int k, prev_k;
  bit prev_eop;
  logic [3:0] acc;

  initial begin
    step; step;
    reset = 1'b0;
    pdrdy = 1'b1;
    repeat (10) begin
      step;
      chk("idle p_srdy", 32'(psrdy_lk), 0);
      chk("idle c_drdy", 32'(drdy_lk), 0);
      chk("idle p_grant", 32'(grant_lk), 0);
    end
    // per-word round robin, everyone requesting single-word packets
    data = 32'h44332211; eop = 4'hf; srdy = 4'hf;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("rr grant", 32'(grant_rr), 32'(1 << (i % 4)));
      chk("rr data", 32'(pdata_rr), 32'h11 * ((i % 4) + 1));
    end
    srdy = 4'h0; step;
    reset = 1'b1; step;
    reset = 1'b0;
    // three-word packet on input 2 with a two-cycle gap
    data = 32'h44332211; eop = 4'b0011; srdy = 4'b0100;
    step;
    chk("lock w1 grant", 32'(grant_lk), 32'h4);
    chk("lock w1 data", 32'(pdata_lk), 32'h33);
    data[23:16] = 8'h34; srdy = 4'b0111;
    step;
    chk("lock w2 grant", 32'(grant_lk), 32'h4);
    chk("lock w2 data", 32'(pdata_lk), 32'h34);
    srdy = 4'b0011;
    #1 chk("gap c_drdy", 32'(drdy_lk), 32'h4);
    step;
    chk("gap p_srdy", 32'(psrdy_lk), 0);
    chk("gap c_drdy 2", 32'(drdy_lk), 32'h4);
    step;
    chk("gap p_srdy 2", 32'(psrdy_lk), 0);
    data[23:16] = 8'h35; eop = 4'b0111; srdy = 4'b0111;
    step;
    chk("lock w3 grant", 32'(grant_lk), 32'h4);
    chk("lock w3 data", 32'(pdata_lk), 32'h35);
    chk("lock w3 eop", 32'(peop_lk), 1);
    srdy = 4'b0011;
    step;
    chk("after pkt grant", 32'(grant_lk), 32'h1);
    // backpressure holds the register and blocks every input
    pdrdy = 1'b0;
    #1 chk("bp c_drdy", 32'(drdy_lk), 0);
    repeat (5) begin
      step;
      chk("bp p_srdy", 32'(psrdy_lk), 1);
      chk("bp p_grant", 32'(grant_lk), 32'h1);
      chk("bp p_data", 32'(pdata_lk), 32'h11);
      chk("bp c_drdy", 32'(drdy_lk), 0);
    end
    pdrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("resume grant", 32'(grant_lk), (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("resume data", 32'(pdata_lk), (i % 2 == 0) ? 32'h22 : 32'h11);
    end
    // reset while locked on input 3
    srdy = 4'b1000; eop = 4'b0;
    step;
    chk("lock3 grant", 32'(grant_lk), 32'h8);
    reset = 1'b1;
    #1;
    chk("async rst p_srdy", 32'(psrdy_lk), 0);
    chk("async rst p_grant", 32'(grant_lk), 0);
    step;
    reset = 1'b0; srdy = 4'hf; eop = 4'hf;
    step;
    chk("post rst grant", 32'(grant_lk), 32'h1);
    // random traffic: per-input sequence numbers in data
    srdy = 4'h0; reset = 1'b1; step;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; outseq[i] = 0;
      data[i*8 +: 8] = {2'(i), 6'd0};
      eop[i] = ($urandom % 3) == 0;
    end
    prev_k = 0; prev_eop = 1'b1;
    repeat (10000) begin
      #1;
      acc = srdy & drdy_lk;
      if (psrdy_lk && pdrdy) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (grant_lk[i]) k = i;
        chk("order", 32'(pdata_lk), 32'({2'(k), 6'(outseq[k])}));
        outseq[k]++;
        if (!prev_eop) chk("interleave", k, prev_k);
        prev_k = k; prev_eop = peop_lk;
      end
      step;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          seq[i]++;
          data[i*8 +: 8] = {2'(i), 6'(seq[i])};
          eop[i] = ($urandom % 3) == 0;
        end
        if (!srdy[i] || acc[i]) srdy[i] = 1'($urandom % 2);
      end
      pdrdy = ($urandom % 4) != 0;
    end
    srdy = 4'h0;
    repeat (3) step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
